// File: rtl/avalon_pio_pkg.sv
// Shared register map and edge-mode encoding for the parametrised Avalon-MM PIO.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_OUTRB   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/pio_edge_detect.sv
// Input synchroniser, previous-sample flop and warm-up-gated per-bit edge pulses.
module pio_edge_detect
  import avalon_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] in_sync,
  output logic [DATA_WIDTH-1:0] edge_pulse,
  output logic                  warm_done
);

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CW       = $clog2(WARM_MAX + 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] in_prev;
  logic [DATA_WIDTH-1:0] raw_edge;
  logic [CW-1:0]         warm_cnt;

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == CW'(WARM_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev  <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= in_sync;
      if (!warm_done) warm_cnt <= warm_cnt + CW'(1);
    end
  end

  generate
    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_fall
      assign raw_edge = ~in_sync & in_prev;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_any
      assign raw_edge = in_sync ^ in_prev;
    end else begin : g_rise
      assign raw_edge = in_sync & ~in_prev;
    end
  endgenerate

  // Until the chain and in_prev hold live samples, the 0->input step is not a real edge.
  assign edge_pulse = warm_done ? raw_edge : '0;

endmodule

// File: rtl/avalon_pio_gen.sv
// Parametrised Avalon-MM PIO: output register, synchronised input, edge capture, IRQ.
// Optional OUTSET/OUTCLR registers are enabled by defining AVALON_PIO_OUTSETCLR_EN.
module avalon_pio_gen
  import avalon_pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] RST_VAL = RESET_VALUE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] out_reg;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] in_sync;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] cap_clr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;
  logic                  warm_done;
  logic                  unused_wdata;

  // Avalon slave, no wait states: a write transfers on any clk edge where
  // chipselect=1 and write_n=0; reads are combinational and side-effect free.
  assign wr_en        = chipselect && !write_n;
  assign wdata        = writedata[DATA_WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign cap_clr      = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;

  pio_edge_detect #(
    .DATA_WIDTH (DATA_WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .in_sync   (in_sync),
    .edge_pulse(edge_pulse),
    .warm_done (warm_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= RST_VAL;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:    out_reg  <= wdata;
          ADDR_IRQMASK: irq_mask <= wdata;
`ifdef AVALON_PIO_OUTSETCLR_EN
          ADDR_OUTSET:  out_reg  <= out_reg | wdata;
          ADDR_OUTCLR:  out_reg  <= out_reg & ~wdata;
`endif
          default: ;
        endcase
      end
      // A new edge overrides a simultaneous write-1-to-clear.
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
    end
  end

  assign out_port = out_reg;
  assign irq      = |(edge_cap & irq_mask);

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:    rd_word = in_sync;
      ADDR_OUTRB:   rd_word = out_reg;
      ADDR_IRQMASK: rd_word = irq_mask;
      ADDR_EDGECAP: rd_word = edge_cap;
      default:      rd_word = '0;
    endcase
    readdata = 32'(rd_word);
  end

endmodule
